// File: rtl/tdm_demux.sv
// tdm_demux: TDM channel-select receiver; define TDM_DEMUX_SHADOW_EN to publish out only on complete frames
module tdm_demux #(
  parameter int CH = 4,
  parameter int W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [W-1:0]            in_data,
  input  logic                    err_clr,
  output logic [CH*W-1:0]         out,
  output logic                    frame_valid,
  output logic [$clog2(CH)-1:0]   ch,
  output logic                    synced,
  output logic                    sync_err
);
  localparam int CW = $clog2(CH);
  typedef enum logic {HUNT, RUN} state_t;
  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_ch, w_ch_nxt, w_idx;
  logic            w_acc, w_last, w_resync, r_fv, r_err;
  logic [CH*W-1:0] r_out, w_base, w_wr;
`ifdef TDM_DEMUX_SHADOW_EN
  logic [CH*W-1:0] r_shadow;
  assign w_base = r_shadow;
`else
  assign w_base = r_out;
`endif
  always_comb begin
    w_acc       = in_valid && (r_state == RUN || in_sof);
    w_last      = w_acc && !in_sof && r_ch == CW'(CH - 1);
    w_resync    = w_acc && in_sof && r_state == RUN && r_ch != '0;
    w_idx       = in_sof ? '0 : r_ch;
    w_ch_nxt    = !w_acc ? r_ch : in_sof ? CW'(1) : w_last ? '0 : r_ch + 1'b1;
    w_state_nxt = w_acc ? RUN : r_state;
    w_wr        = w_base;
    if (w_acc) w_wr[w_idx*W +: W] = in_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_ch    <= '0;
      r_out   <= '0;
      r_fv    <= 1'b0;
      r_err   <= 1'b0;
`ifdef TDM_DEMUX_SHADOW_EN
      r_shadow <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_fv    <= w_last;
      r_err   <= w_resync | (r_err & ~err_clr);
`ifdef TDM_DEMUX_SHADOW_EN
      r_shadow <= w_wr;
      if (w_last) r_out <= w_wr;
`else
      r_out <= w_wr;
`endif
    end
  end
  assign out         = r_out;
  assign frame_valid = r_fv;
  assign ch          = r_ch;
  assign synced      = r_state == RUN;
  assign sync_err    = r_err;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: scoreboard bench for tdm_demux (CH=4, W=8); expected frames queued on drive, popped on frame_valid
module tb_tdm_demux;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [7:0]  in_data = '0;
  logic        err_clr = 1'b0;
  logic [31:0] out;
  logic        frame_valid;
  logic [1:0]  ch;
  logic        synced;
  logic        sync_err;
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_err = 0;

  tdm_demux #(.CH(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .err_clr(err_clr), .out(out), .frame_valid(frame_valid), .ch(ch), .synced(synced),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic send(input logic v, input logic s, input logic [7:0] d);
    logic [31:0] e;
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    err_clr  = 1'b0;
    if (frame_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL frame_valid_unexpected: got 1 want 0 (out=%h)", out);
      end else begin
        e = exp_q.pop_front();
        if (out !== e) begin
          n_err++;
          $display("FAIL frame_out: got %h want %h", out, e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame(input logic [7:0] d0, d1, d2, d3);
    exp_q.push_back({d3, d2, d1, d0});
    send(1'b1, 1'b1, d0);
    send(1'b1, 1'b0, d1);
    send(1'b1, 1'b0, d2);
    send(1'b1, 1'b0, d3);
  endtask

  task automatic drain(input string name);
    idle(2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_missing_frame_valid: got %0d pending want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_vals(input string name);
    n_checks++;
    if ({out, frame_valid, ch, synced, sync_err} !== 37'h0) begin
      n_err++;
      $display("FAIL %s: got out=%h fv=%b ch=%0d synced=%b err=%b want all 0",
               name, out, frame_valid, ch, synced, sync_err);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_values");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    #3;
    check_reset_vals("power_on_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    exp_q.push_back(32'hA4A3A2A1);
    send(1'b1, 1'b1, 8'hA1);
    n_checks++;
    if (ch !== 2'd1 || synced !== 1'b1) begin
      n_err++;
      $display("FAIL basic_first_beat: got ch=%0d synced=%b want ch=1 synced=1", ch, synced);
    end
    send(1'b1, 1'b0, 8'hA2);
    send(1'b1, 1'b0, 8'hA3);
    send(1'b1, 1'b0, 8'hA4);
    n_checks++;
    if (ch !== 2'd0 || synced !== 1'b1 || frame_valid !== 1'b1) begin
      n_err++;
      $display("FAIL basic_end: got ch=%0d synced=%b fv=%b want 0 1 1", ch, synced, frame_valid);
    end
    drain("basic");
  endtask

  task automatic test_hunt();
    do_reset();
    send(1'b1, 1'b0, 8'h11);
    send(1'b1, 1'b0, 8'h22);
    n_checks++;
    if (out !== 32'h0 || synced !== 1'b0 || ch !== 2'd0) begin
      n_err++;
      $display("FAIL hunt_discard: got out=%h synced=%b ch=%0d want 0 0 0", out, synced, ch);
    end
    frame(8'h33, 8'h44, 8'h55, 8'h66);
    drain("hunt");
  endtask

  task automatic test_resync();
    send(1'b1, 1'b0, 8'h01);
    send(1'b1, 1'b0, 8'h02);
    n_checks++;
`ifdef TDM_DEMUX_SHADOW_EN
    if (out !== 32'h66554433) begin
      n_err++;
      $display("FAIL resync_partial_hidden: got %h want 66554433", out);
    end
`else
    if (out !== 32'h66550201) begin
      n_err++;
      $display("FAIL resync_partial_visible: got %h want 66550201", out);
    end
`endif
    exp_q.push_back(32'h40302010);
    send(1'b1, 1'b1, 8'h10);
    n_checks++;
    if (sync_err !== 1'b1 || ch !== 2'd1 || synced !== 1'b1) begin
      n_err++;
      $display("FAIL resync_flag: got err=%b ch=%0d synced=%b want 1 1 1", sync_err, ch, synced);
    end
    send(1'b1, 1'b0, 8'h20);
    send(1'b1, 1'b0, 8'h30);
    send(1'b1, 1'b0, 8'h40);
    drain("resync");
  endtask

  task automatic test_gap();
    exp_q.push_back(32'hB4B3B2B1);
    send(1'b1, 1'b1, 8'hB1);
    send(1'b1, 1'b0, 8'hB2);
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 1'b0, 8'hEE);
      n_checks++;
      if (ch !== 2'd2) begin
        n_err++;
        $display("FAIL gap_hold[%0d]: got ch=%0d want 2", i, ch);
      end
    end
    send(1'b1, 1'b0, 8'hB3);
    send(1'b1, 1'b0, 8'hB4);
    drain("gap");
  endtask

  task automatic test_back_to_back();
    frame(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    frame(8'hD1, 8'hD2, 8'hD3, 8'hD4);
    frame(8'hE1, 8'hE2, 8'hE3, 8'hE4);
    drain("back_to_back");
  endtask

  task automatic test_err_clr();
    err_clr = 1'b1;
    send(1'b0, 1'b0, 8'h00);
    n_checks++;
    if (sync_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clr_prep: got %b want 0", sync_err);
    end
    send(1'b1, 1'b0, 8'h05);
    err_clr = 1'b1;
    exp_q.push_back(32'h5A595857);
    send(1'b1, 1'b1, 8'h57);
    n_checks++;
    if (sync_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_set_wins: got %b want 1", sync_err);
    end
    err_clr = 1'b1;
    send(1'b1, 1'b0, 8'h58);
    n_checks++;
    if (sync_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clr_alone: got %b want 0", sync_err);
    end
    send(1'b1, 1'b0, 8'h59);
    send(1'b1, 1'b0, 8'h5A);
    drain("err_clr");
  endtask

  task automatic test_reset_mid();
    send(1'b1, 1'b1, 8'hF1);
    send(1'b1, 1'b0, 8'hF2);
    send(1'b1, 1'b0, 8'hF3);
    do_reset();
    send(1'b1, 1'b0, 8'hF4);
    send(1'b1, 1'b0, 8'h77);
    n_checks++;
    if (synced !== 1'b0 || out !== 32'h0 || ch !== 2'd0) begin
      n_err++;
      $display("FAIL post_reset_hunt: got synced=%b out=%h ch=%0d want 0 0 0", synced, out, ch);
    end
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hunt();
    test_resync();
    test_gap();
    test_back_to_back();
    test_err_clr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
